// File: rtl/rlwe_enc2_mul_arbiter.sv
// Round-robin arbiter feeding one shared unsigned A_W x B_W multiplier.
// Two register stages: S1 holds the granted operands, S2 holds the product.
// Each result carries the index of the requester that issued it, and
// res_ready backpressure stalls the pipeline.
module rlwe_enc2_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 14,
    parameter int B_W     = 16,
    parameter int P_W     = 30,
    parameter int ID_W    = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [P_W-1:0]         res_p,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);

    // Pipeline state
    logic            s1_v_reg;
    logic [A_W-1:0]  s1_a_reg;
    logic [B_W-1:0]  s1_b_reg;
    logic [ID_W-1:0] s1_id_reg;
    logic            s2_v_reg;
    logic [P_W-1:0]  s2_p_reg;
    logic [ID_W-1:0] s2_id_reg;
    logic [ID_W-1:0] ptr_reg;

    // Unpacked per-requester operand views
    logic [A_W-1:0]  a_arr [NUM_REQ];
    logic [B_W-1:0]  b_arr [NUM_REQ];

    logic            s2_adv;
    logic            accept;
    logic            found;
    logic [ID_W-1:0] winner;
    logic            xfer;
    logic [ID_W-1:0] ptr_next;
    logic [P_W-1:0]  product;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*A_W +: A_W];
            assign b_arr[gi] = req_b[gi*B_W +: B_W];
        end
    endgenerate

    // S2 can take new data when it is empty or being drained this cycle;
    // S1 can take a new request when it is empty or moving into S2.
    assign s2_adv = !s2_v_reg || res_ready;
    assign accept = !s1_v_reg || s2_adv;
    assign xfer   = found && accept;

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ
    always_comb begin
        int              idx_int;
        logic [ID_W-1:0] idx;
        found   = 1'b0;
        winner  = '0;
        idx_int = 0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_int = (int'(ptr_reg) + k) % NUM_REQ;
            idx     = ID_W'(idx_int);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant is one-hot on the winner, and suppressed while reset is held
    always_comb begin
        req_ready = '0;
        if (found && accept && ap_rst_n) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Pointer moves one past the winner, wrapping after the last requester
    always_comb begin
        ptr_next = winner + ID_W'(1);
        if (winner == ID_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end
    end

    // Full-width unsigned product of the S1 operands
    assign product = P_W'(s1_a_reg) * P_W'(s1_b_reg);

    // Pipeline registers and round-robin pointer
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_v_reg  <= 1'b0;
            s1_a_reg  <= '0;
            s1_b_reg  <= '0;
            s1_id_reg <= '0;
            s2_v_reg  <= 1'b0;
            s2_p_reg  <= '0;
            s2_id_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            if (s2_adv) begin
                s2_v_reg  <= s1_v_reg;
                s2_p_reg  <= product;
                s2_id_reg <= s1_id_reg;
            end
            if (accept) begin
                s1_v_reg <= xfer;
                if (xfer) begin
                    s1_a_reg  <= a_arr[winner];
                    s1_b_reg  <= b_arr[winner];
                    s1_id_reg <= winner;
                    ptr_reg   <= ptr_next;
                end
            end
        end
    end

    assign res_valid = s2_v_reg;
    assign res_p     = s2_p_reg;
    assign res_id    = s2_id_reg;
    assign busy      = s1_v_reg || s2_v_reg;

endmodule
